mig_axi_slave_mem: RTL and testbench

AXI4 responder (slave) backed by an internal DEPTH x C_AXI_DATA_WIDTH register array. It acts as a bench/on-chip stand-in for the MIG DDR port and answers the burst master.

---
 rtl/mig_axi_slave_mem.sv | 238 +++++++++++++++++++++++
 tb/tb_mig_axi_slave_mem.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mig_axi_slave_mem.sv
// mig_axi_slave_mem
//   AXI4 responder backed by an internal DEPTH x C_AXI_DATA_WIDTH memory.
//   It stands in for a MIG DDR port and answers a burst master.
//   There is one write burst and one read burst in flight at a time, on independent paths.
//   Bursts are INCR and use the full bus width: one word per beat.
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   axi_aw*             write address channel (id, byte address, len = beats-1)
//   axi_w*              write data channel (data, byte strobes, last)
//   axi_b*              write response channel (id echo, OKAY / SLVERR)
//   axi_ar*             read address channel (id, byte address, len = beats-1)
//   axi_r*              read data channel (id echo, registered data, resp, last)
module mig_axi_slave_mem #(
  parameter int C_AXI_ID_WIDTH   = 4,
  parameter int C_AXI_ADDR_WIDTH = 64,
  parameter int C_AXI_DATA_WIDTH = 256,
  parameter int DEPTH            = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [C_AXI_ID_WIDTH-1:0]     axi_awid,
  input  logic [C_AXI_ADDR_WIDTH-1:0]   axi_awaddr,
  input  logic [7:0]                    axi_awlen,
  input  logic                          axi_awvalid,
  output logic                          axi_awready,
  input  logic [C_AXI_DATA_WIDTH-1:0]   axi_wdata,
  input  logic [C_AXI_DATA_WIDTH/8-1:0] axi_wstrb,
  input  logic                          axi_wlast,
  input  logic                          axi_wvalid,
  output logic                          axi_wready,
  output logic [C_AXI_ID_WIDTH-1:0]     axi_bid,
  output logic [1:0]                    axi_bresp,
  output logic                          axi_bvalid,
  input  logic                          axi_bready,
  input  logic [C_AXI_ID_WIDTH-1:0]     axi_arid,
  input  logic [C_AXI_ADDR_WIDTH-1:0]   axi_araddr,
  input  logic [7:0]                    axi_arlen,
  input  logic                          axi_arvalid,
  output logic                          axi_arready,
  output logic [C_AXI_ID_WIDTH-1:0]     axi_rid,
  output logic [C_AXI_DATA_WIDTH-1:0]   axi_rdata,
  output logic [1:0]                    axi_rresp,
  output logic                          axi_rlast,
  output logic                          axi_rvalid,
  input  logic                          axi_rready
);

  localparam int NBYTES = C_AXI_DATA_WIDTH / 8;
  localparam int OFFS_W = $clog2(NBYTES);
  localparam int IDX_W  = $clog2(DEPTH);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  // Write path state
  w_state_t                  w_state_reg;
  logic [IDX_W-1:0]          w_idx_reg;
  logic [7:0]                w_len_reg;
  logic [7:0]                w_cnt_reg;
  logic                      w_err_reg;
  logic                      awready_reg;
  logic                      wready_reg;
  logic                      bvalid_reg;
  logic [1:0]                bresp_reg;
  logic [C_AXI_ID_WIDTH-1:0] bid_reg;

  // Read path state
  r_state_t                  r_state_reg;
  logic [IDX_W-1:0]          r_idx_reg;
  logic [7:0]                r_len_reg;
  logic [7:0]                r_cnt_reg;
  logic                      arready_reg;
  logic                      rvalid_reg;
  logic                      rlast_reg;
  logic [C_AXI_ID_WIDTH-1:0] rid_reg;

  logic             aw_fire;
  logic             w_fire;
  logic             w_last_beat;
  logic             w_err_next;
  logic             ar_fire;
  logic             r_fire;
  logic             mem_we;
  logic             mem_rd_en;
  logic [IDX_W-1:0] mem_rd_idx;

  // The ready flags are only raised in their own state, so a handshake implies the state.
  assign aw_fire     = axi_awvalid && awready_reg;
  assign w_fire      = axi_wvalid && wready_reg;
  assign w_last_beat = (w_cnt_reg == w_len_reg);
  // wlast must agree with the beat counter on every beat; any disagreement poisons the burst.
  assign w_err_next  = w_err_reg || (axi_wlast != w_last_beat);
  assign ar_fire     = axi_arvalid && arready_reg;
  assign r_fire      = rvalid_reg && axi_rready;

  // A reset aborts the burst at once, so the beat sampled on the reset edge is not stored.
  assign mem_we     = w_fire && !rst;
  // Prefetch the next word only when the current beat is consumed, so the output holds under stall.
  assign mem_rd_en  = ar_fire || (r_fire && !rlast_reg);
  assign mem_rd_idx = ar_fire ? axi_araddr[OFFS_W +: IDX_W] : r_idx_reg + IDX_W'(1);

  // The byte offset and the address bits above the memory span do not select storage.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{axi_awaddr[C_AXI_ADDR_WIDTH-1:OFFS_W+IDX_W], axi_awaddr[OFFS_W-1:0],
                              axi_araddr[C_AXI_ADDR_WIDTH-1:OFFS_W+IDX_W], axi_araddr[OFFS_W-1:0]};

  // One memory per byte lane: strobes map onto independent lane write enables.
  // A read and a write to the same word on one edge return the old lane contents.
  for (genvar gi = 0; gi < NBYTES; gi++) begin : g_lane
    logic [7:0] lane_mem [DEPTH];
    logic [7:0] rdata_lane_reg;

    always_ff @(posedge clk) begin
      if (mem_we && axi_wstrb[gi]) begin
        lane_mem[w_idx_reg] <= axi_wdata[gi*8 +: 8];
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        rdata_lane_reg <= '0;
      end else if (mem_rd_en) begin
        rdata_lane_reg <= lane_mem[mem_rd_idx];
      end
    end

    assign axi_rdata[gi*8 +: 8] = rdata_lane_reg;
  end

  // Write FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_reg <= W_IDLE;
      w_idx_reg   <= '0;
      w_len_reg   <= '0;
      w_cnt_reg   <= '0;
      w_err_reg   <= 1'b0;
      awready_reg <= 1'b1;
      wready_reg  <= 1'b0;
      bvalid_reg  <= 1'b0;
      bresp_reg   <= 2'b00;
      bid_reg     <= '0;
    end else begin
      case (w_state_reg)
        W_IDLE: begin
          if (aw_fire) begin
            bid_reg     <= axi_awid;
            w_idx_reg   <= axi_awaddr[OFFS_W +: IDX_W];
            w_len_reg   <= axi_awlen;
            w_cnt_reg   <= '0;
            w_err_reg   <= 1'b0;
            awready_reg <= 1'b0;
            wready_reg  <= 1'b1;
            w_state_reg <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_fire) begin
            w_idx_reg <= w_idx_reg + IDX_W'(1);
            w_cnt_reg <= w_cnt_reg + 8'd1;
            w_err_reg <= w_err_next;
            // The burst length comes from awlen alone; wlast only feeds the error flag.
            if (w_last_beat) begin
              wready_reg  <= 1'b0;
              bvalid_reg  <= 1'b1;
              bresp_reg   <= w_err_next ? 2'b10 : 2'b00;
              w_state_reg <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (axi_bready) begin
            bvalid_reg  <= 1'b0;
            awready_reg <= 1'b1;
            w_state_reg <= W_IDLE;
          end
        end
        default: w_state_reg <= W_IDLE;
      endcase
    end
  end

  // Read FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_reg <= R_IDLE;
      r_idx_reg   <= '0;
      r_len_reg   <= '0;
      r_cnt_reg   <= '0;
      arready_reg <= 1'b1;
      rvalid_reg  <= 1'b0;
      rlast_reg   <= 1'b0;
      rid_reg     <= '0;
    end else begin
      case (r_state_reg)
        R_IDLE: begin
          if (ar_fire) begin
            rid_reg     <= axi_arid;
            r_idx_reg   <= axi_araddr[OFFS_W +: IDX_W];
            r_len_reg   <= axi_arlen;
            r_cnt_reg   <= '0;
            arready_reg <= 1'b0;
            rvalid_reg  <= 1'b1;
            rlast_reg   <= (axi_arlen == 8'd0);
            r_state_reg <= R_DATA;
          end
        end
        R_DATA: begin
          if (r_fire) begin
            if (rlast_reg) begin
              rvalid_reg  <= 1'b0;
              rlast_reg   <= 1'b0;
              arready_reg <= 1'b1;
              r_state_reg <= R_IDLE;
            end else begin
              r_idx_reg <= r_idx_reg + IDX_W'(1);
              r_cnt_reg <= r_cnt_reg + 8'd1;
              rlast_reg <= ((r_cnt_reg + 8'd1) == r_len_reg);
            end
          end
        end
        default: r_state_reg <= R_IDLE;
      endcase
    end
  end

  assign axi_awready = awready_reg;
  assign axi_wready  = wready_reg;
  assign axi_bvalid  = bvalid_reg;
  assign axi_bresp   = bresp_reg;
  assign axi_bid     = bid_reg;
  assign axi_arready = arready_reg;
  assign axi_rvalid  = rvalid_reg;
  assign axi_rlast   = rlast_reg;
  assign axi_rid     = rid_reg;
  assign axi_rresp   = 2'b00;

endmodule

// File: tb/tb_mig_axi_slave_mem.sv
// tb_mig_axi_slave_mem
//   Scoreboard bench for mig_axi_slave_mem.
//   A reference memory array holds the expected contents.
//   Stimulus tasks queue the expected B and R responses when they issue a burst.
//   A monitor process pops and compares those responses whenever a handshake is presented.
module tb_mig_axi_slave_mem;

  localparam int IDW   = 4;
  localparam int AW    = 64;
  localparam int DW    = 256;
  localparam int DEPTH = 1024;
  localparam int SW    = DW / 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [IDW-1:0]  axi_awid;
  logic [AW-1:0]   axi_awaddr;
  logic [7:0]      axi_awlen;
  logic            axi_awvalid;
  logic            axi_awready;
  logic [DW-1:0]   axi_wdata;
  logic [SW-1:0]   axi_wstrb;
  logic            axi_wlast;
  logic            axi_wvalid;
  logic            axi_wready;
  logic [IDW-1:0]  axi_bid;
  logic [1:0]      axi_bresp;
  logic            axi_bvalid;
  logic            axi_bready;
  logic [IDW-1:0]  axi_arid;
  logic [AW-1:0]   axi_araddr;
  logic [7:0]      axi_arlen;
  logic            axi_arvalid;
  logic            axi_arready;
  logic [IDW-1:0]  axi_rid;
  logic [DW-1:0]   axi_rdata;
  logic [1:0]      axi_rresp;
  logic            axi_rlast;
  logic            axi_rvalid;
  logic            axi_rready;

  always #5 clk = ~clk;

  mig_axi_slave_mem #(
    .C_AXI_ID_WIDTH(IDW), .C_AXI_ADDR_WIDTH(AW), .C_AXI_DATA_WIDTH(DW), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .axi_awid(axi_awid), .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen),
    .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_bid(axi_bid), .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
    .axi_arid(axi_arid), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen),
    .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_rid(axi_rid), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rlast(axi_rlast),
    .axi_rvalid(axi_rvalid), .axi_rready(axi_rready)
  );

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [DW-1:0]  data;
    logic           last;
  } rexp_t;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [1:0]     resp;
  } bexp_t;

  logic [DW-1:0] model_mem [DEPTH];
  rexp_t         rq[$];
  bexp_t         bq[$];
  int            checks = 0;
  int            passed = 0;
  int            rmode  = 0;   // 0 random, 1 toggle, 2 always ready
  int            bmode  = 0;   // 0 random, 1 always ready

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w;
    for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  function automatic int word_index(input logic [AW-1:0] addr);
    return int'((addr / SW) % DEPTH);
  endfunction

  // Ready drivers, updated just after each rising edge
  initial begin
    axi_rready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rmode)
        0:       axi_rready = 1'($urandom_range(0, 1));
        1:       axi_rready = ~axi_rready;
        default: axi_rready = 1'b1;
      endcase
    end
  end

  initial begin
    axi_bready = 1'b0;
    forever begin
      @(posedge clk); #1;
      axi_bready = (bmode == 0) ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: on the falling edge, a valid&&ready pair means a handshake on the next rising edge.
  logic          hold_v = 1'b0;
  logic [DW-1:0] hold_d;
  logic          hold_l;
  initial begin
    rexp_t re;
    bexp_t be;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_v = 1'b0;
      end else begin
        if (hold_v) begin
          check("r_hold_valid", DW'(axi_rvalid), DW'(1'b1));
          check("r_hold_data", axi_rdata, hold_d);
          check("r_hold_last", DW'(axi_rlast), DW'(hold_l));
        end
        if (axi_rvalid && axi_rready) begin
          if (rq.size() == 0) begin
            check("r_unexpected_beat", DW'(1'b1), DW'(1'b0));
          end else begin
            re = rq.pop_front();
            check("r_data", axi_rdata, re.data);
            check("r_last", DW'(axi_rlast), DW'(re.last));
            check("r_id", DW'(axi_rid), DW'(re.id));
            check("r_resp", DW'(axi_rresp), DW'(2'b00));
          end
        end
        hold_v = axi_rvalid && !axi_rready;
        hold_d = axi_rdata;
        hold_l = axi_rlast;
        if (axi_bvalid && axi_bready) begin
          if (bq.size() == 0) begin
            check("b_unexpected", DW'(1'b1), DW'(1'b0));
          end else begin
            be = bq.pop_front();
            check("b_id", DW'(axi_bid), DW'(be.id));
            check("b_resp", DW'(axi_bresp), DW'(be.resp));
          end
        end
      end
    end
  end

  // All driver tasks start and end just after a rising edge.
  task automatic drain(input int budget);
    int t = 0;
    while ((rq.size() != 0 || bq.size() != 0) && t < budget) begin
      @(negedge clk);
      t++;
    end
    if (rq.size() != 0 || bq.size() != 0) begin
      check("drain_timeout", DW'(1'b0), DW'(1'b1));
      rq.delete();
      bq.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic aw_send(input logic [IDW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len);
    int t = 0;
    axi_awid = id; axi_awaddr = addr; axi_awlen = len; axi_awvalid = 1'b1;
    @(negedge clk);
    while (!axi_awready && t < 300) begin @(negedge clk); t++; end
    if (!axi_awready) check("aw_timeout", DW'(1'b0), DW'(1'b1));
    @(posedge clk); #1;
    axi_awvalid = 1'b0;
  endtask

  task automatic ar_send(input logic [IDW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len);
    int t = 0;
    axi_arid = id; axi_araddr = addr; axi_arlen = len; axi_arvalid = 1'b1;
    @(negedge clk);
    while (!axi_arready && t < 300) begin @(negedge clk); t++; end
    if (!axi_arready) check("ar_timeout", DW'(1'b0), DW'(1'b1));
    @(posedge clk); #1;
    axi_arvalid = 1'b0;
  endtask

  // wlast_at < 0 puts wlast on the final beat; strb_mode 0 full, 1 random, 2 low byte-group only.
  // abort_at >= 0 pulses reset in place of that beat and checks the write channel returns to idle.
  task automatic write_burst(input logic [IDW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                             input int wlast_at, input int strb_mode, input int abort_at, input bit drain_after);
    int idx = word_index(addr);
    int t;
    logic [DW-1:0] d;
    logic [SW-1:0] s;
    bexp_t be;
    if (abort_at < 0) begin
      be.id = id;
      be.resp = (wlast_at >= 0 && wlast_at != int'(len)) ? 2'b10 : 2'b00;
      bq.push_back(be);
    end
    aw_send(id, addr, len);
    for (int b = 0; b <= int'(len); b++) begin
      axi_wvalid = 1'b0;
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      if (b == abort_at) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_awready", DW'(axi_awready), DW'(1'b1));
        check("abort_wready", DW'(axi_wready), DW'(1'b0));
        check("abort_bvalid", DW'(axi_bvalid), DW'(1'b0));
        @(posedge clk); #1;
        return;
      end
      d = rand_word();
      case (strb_mode)
        0:       s = '1;
        1:       s = SW'({$urandom, $urandom});
        default: s = SW'(32'h0000_00FF);
      endcase
      axi_wdata = d;
      axi_wstrb = s;
      axi_wlast = (wlast_at < 0) ? (b == int'(len)) : (b == wlast_at);
      axi_wvalid = 1'b1;
      t = 0;
      @(negedge clk);
      while (!axi_wready && t < 300) begin @(negedge clk); t++; end
      if (!axi_wready) check("w_timeout", DW'(1'b0), DW'(1'b1));
      for (int k = 0; k < SW; k++) begin
        if (s[k]) model_mem[idx][k*8 +: 8] = d[k*8 +: 8];
      end
      @(posedge clk); #1;
      idx = (idx + 1) % DEPTH;
    end
    axi_wvalid = 1'b0;
    axi_wlast  = 1'b0;
    if (drain_after) drain(2000);
  endtask

  task automatic queue_read(input logic [IDW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len);
    int idx = word_index(addr);
    rexp_t re;
    for (int b = 0; b <= int'(len); b++) begin
      re.id = id;
      re.data = model_mem[idx];
      re.last = (b == int'(len));
      rq.push_back(re);
      idx = (idx + 1) % DEPTH;
    end
  endtask

  task automatic read_burst(input logic [IDW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len);
    queue_read(id, addr, len);
    ar_send(id, addr, len);
    drain(4000);
  endtask

  initial begin
    logic [IDW-1:0] rid;
    logic [AW-1:0]  waddr;
    logic [AW-1:0]  raddr;
    logic [7:0]     wlen;
    logic [7:0]     rlen;
    int             wl;

    rst = 1'b1;
    axi_awid = '0; axi_awaddr = '0; axi_awlen = '0; axi_awvalid = 1'b0;
    axi_wdata = '0; axi_wstrb = '0; axi_wlast = 1'b0; axi_wvalid = 1'b0;
    axi_arid = '0; axi_araddr = '0; axi_arlen = '0; axi_arvalid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_awready", DW'(axi_awready), DW'(1'b1));
    check("rst_arready", DW'(axi_arready), DW'(1'b1));
    check("rst_wready", DW'(axi_wready), DW'(1'b0));
    check("rst_bvalid", DW'(axi_bvalid), DW'(1'b0));
    check("rst_rvalid", DW'(axi_rvalid), DW'(1'b0));
    check("rst_rlast", DW'(axi_rlast), DW'(1'b0));
    check("rst_bresp", DW'(axi_bresp), DW'(2'b00));
    check("rst_bid", DW'(axi_bid), DW'(4'h0));
    check("rst_rid", DW'(axi_rid), DW'(4'h0));
    check("rst_rdata", axi_rdata, DW'(0));
    @(posedge clk); #1;

    // Give every word a known value so that any later read has a defined expectation.
    bmode = 1;
    for (int f = 0; f < DEPTH / 256; f++) write_burst(4'h1, AW'(f * 256 * SW), 8'd255, -1, 0, -1, 1'b1);
    bmode = 0;

    // Eight-beat write then readback, rlast only on the eighth beat
    write_burst(4'h3, 64'h0, 8'd7, -1, 0, -1, 1'b1);
    read_burst(4'h5, 64'h0, 8'd7);

    // Partial strobe over word 0: only the low byte-group changes
    write_burst(4'h6, 64'h0, 8'd0, -1, 2, -1, 1'b1);
    read_burst(4'h7, 64'h0, 8'd0);

    // Early wlast: all four beats still taken, response is SLVERR
    write_burst(4'h9, 64'h400, 8'd3, 1, 0, -1, 1'b1);
    read_burst(4'hA, 64'h400, 8'd3);

    // Sixteen-beat read against a master that stalls every other cycle
    rmode = 1;
    read_burst(4'hB, 64'h100, 8'd15);
    rmode = 0;

    // Burst crossing the top of the memory wraps to word 0
    write_burst(4'hC, AW'((DEPTH - 2) * SW), 8'd3, -1, 0, -1, 1'b1);
    read_burst(4'hD, AW'((DEPTH - 2) * SW), 8'd3);

    // Reset during the fourth write beat, then a fresh burst completes with OKAY
    write_burst(4'hE, 64'h2000, 8'd7, -1, 0, 3, 1'b1);
    read_burst(4'h2, 64'h2000, 8'd7);
    write_burst(4'h4, 64'h3000, 8'd3, -1, 1, -1, 1'b1);
    read_burst(4'h8, 64'h3000, 8'd3);

    // Write and read on disjoint ranges at the same time
    queue_read(4'hF, 64'h4000, 8'd9);
    fork
      write_burst(4'h1, 64'h5000, 8'd9, -1, 1, -1, 1'b0);
      ar_send(4'hF, 64'h4000, 8'd9);
    join
    drain(4000);
    read_burst(4'h0, 64'h5000, 8'd9);

    // Randomised bursts with arbitrary upper address bits and occasional bad wlast
    for (int it = 0; it < 24; it++) begin
      waddr = {$urandom, $urandom};
      wlen  = 8'($urandom_range(0, 15));
      wl    = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) % (int'(wlen) + 1) : -1;
      write_burst(IDW'($urandom), waddr, wlen, wl, int'($urandom_range(0, 1)), -1, 1'b1);
      raddr = $urandom_range(0, 1) ? waddr : {$urandom, $urandom};
      rlen  = 8'($urandom_range(0, 15));
      rid   = IDW'($urandom);
      rmode = int'($urandom_range(0, 2));
      read_burst(rid, raddr, rlen);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
